irq_ctrl: RTL

Parametrised interrupt controller that replaces the fixed 4-input combinational priority encoder feeding the AVR core's `iflag`/`ivect` inputs. Each of `NIRQ` request lines has a pending latch, a per-channel edge/level mode and an enable mask. A fixed-priority selector (lowest index wins) drives registered `iflag`/`ivect`. The block sits in one MMIO slot (0xfN00) so firmware can mask, inspect and clear sources. Core interrupt acknowledge clears the serviced edge-mode source.

---
 rtl/irq_ctrl_pkg.sv | 24 ++
 rtl/irq_prio_enc.sv | 24 ++
 rtl/irq_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, MMIO slot
// and a byte-lane helper used by the read path.
package irq_ctrl_pkg;

   // Register index, taken from addr[3:2].
   typedef enum logic [1:0] {
      IRQ_ENABLE  = 2'd0,
      IRQ_PENDING = 2'd1,
      IRQ_MODE    = 2'd2,
      IRQ_STATUS  = 2'd3
   } irq_reg_e;

   // N in the 0xfN00 MMIO window decoded by the system bus.
   localparam logic [3:0] IRQ_MMIO_SLOT = 4'h3;

   // Widest channel count the byte-lane map can address (4 lanes x 8).
   localparam int IRQ_MAX_CH = 32;

   // Pick byte lane 'lane' out of a zero-padded 32-bit channel vector.
   function automatic logic [7:0] lane_byte(input logic [31:0] v, input logic [1:0] lane);
      return v[{lane, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority selector: lowest set index wins.
// vect is 0 when nothing is requested; the parent registers both outputs.
module irq_prio_enc #(
   parameter int NIRQ = 8,
   parameter int IVW  = 3
) (
   input  logic [NIRQ-1:0] req,
   output logic            any,
   output logic [IVW-1:0]  vect
);

   // Scan from the top down so the last hit (lowest index) sticks.
   always_comb begin
      any  = 1'b0;
      vect = '0;
      for (int i = NIRQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            any  = 1'b1;
            vect = IVW'(i);
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Parametrised interrupt controller: per-channel pending latch, edge/level
// mode and enable mask, with a registered lowest-index-first iflag/ivect
// and a small byte-laned MMIO register file.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NIRQ = 8,
   parameter int IVW  = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NIRQ-1:0] irq_in,
   input  logic            ack,
   input  logic [IVW-1:0]  ack_vect,
   output logic            iflag,
   output logic [IVW-1:0]  ivect,
   input  logic            re,
   input  logic            we,
   input  logic [3:0]      addr,
   input  logic [7:0]      wdata,
   output logic [7:0]      rdata
);

   // Refuse to build a controller whose vector cannot name every channel.
   if (NIRQ < 1 || NIRQ > IRQ_MAX_CH || (1 << IVW) < NIRQ) begin : g_bad_cfg
      $error("irq_ctrl: need 1 <= NIRQ <= 32 and 2**IVW >= NIRQ");
   end

   logic [NIRQ-1:0] en_q, en_d;
   logic [NIRQ-1:0] mode_q, mode_d;
   logic [NIRQ-1:0] latch_q, latch_d;
   logic [NIRQ-1:0] prev_q;
   logic            iflag_q;
   logic [IVW-1:0]  ivect_q;
   logic [7:0]      rdata_q, rdata_d;

   logic [NIRQ-1:0] pend_vis;
   logic [NIRQ-1:0] active;
   logic [NIRQ-1:0] clr;
   logic [NIRQ-1:0] rise;
   logic            sel_any;
   logic [IVW-1:0]  sel_vect;
   logic [31:0]     rd_vec;
   irq_reg_e        reg_sel;

   assign reg_sel = irq_reg_e'(addr[3:2]);

   // Level channels expose the raw line; edge channels expose their latch.
   always_comb begin
      pend_vis = (mode_q & latch_q) | (~mode_q & irq_in);
      active   = pend_vis & en_q;
      rise     = irq_in & ~prev_q;
   end

   irq_prio_enc #(
      .NIRQ (NIRQ),
      .IVW  (IVW)
   ) u_prio (
      .req  (active),
      .any  (sel_any),
      .vect (sel_vect)
   );

   // Register writes and latch clear sources (W1C and core acknowledge).
   // Lanes beyond NIRQ never match a channel, so their writes vanish.
   always_comb begin
      en_d   = en_q;
      mode_d = mode_q;
      clr    = '0;
      for (int i = 0; i < NIRQ; i++) begin
         if (we && addr[1:0] == 2'(i / 8)) begin
            case (reg_sel)
               IRQ_ENABLE:  en_d[i]   = wdata[3'(i % 8)];
               IRQ_MODE:    mode_d[i] = wdata[3'(i % 8)];
               IRQ_PENDING: clr[i]    = wdata[3'(i % 8)];
               default:     ;
            endcase
         end
         // Out-of-range ack vectors match no channel and are dropped.
         if (ack && ack_vect == IVW'(i)) clr[i] = 1'b1;
      end
      // A new edge beats a same-cycle clear; a level channel holds 0.
      latch_d = mode_d & (rise | (latch_q & ~clr));
   end

   // Read mux; the value is captured before any same-cycle write lands.
   always_comb begin
      rd_vec = '0;
      case (reg_sel)
         IRQ_ENABLE:  rd_vec = 32'(en_q);
         IRQ_PENDING: rd_vec = 32'(pend_vis);
         IRQ_MODE:    rd_vec = 32'(mode_q);
         IRQ_STATUS:  rd_vec = 32'(irq_in);
         default:     rd_vec = '0;
      endcase
      rdata_d = re ? lane_byte(rd_vec, addr[1:0]) : rdata_q;
   end

   // State register; reset clears everything asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_q    <= '0;
         mode_q  <= '0;
         latch_q <= '0;
         prev_q  <= '0;
         iflag_q <= 1'b0;
         ivect_q <= '0;
         rdata_q <= '0;
      end else begin
         en_q    <= en_d;
         mode_q  <= mode_d;
         latch_q <= latch_d;
         prev_q  <= irq_in;
         iflag_q <= sel_any;
         ivect_q <= sel_vect;
         rdata_q <= rdata_d;
      end
   end

   assign iflag = iflag_q;
   assign ivect = ivect_q;
   assign rdata = rdata_q;

endmodule
